// File: rtl/compare_sort_ctrl.sv
// compare_sort_ctrl
//
// Loads a burst of DEPTH unsigned words, bubble-sorts them in place with one
// compare per cycle through a single magnitude comparator, then streams the
// sorted words out, index 0 first.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   producer presents in_data
//   in_data    word to load
//   in_ready   block accepts a word this cycle (LOAD only)
//   descend    sort order, latched with the last word of the burst (1 = descending)
//   out_valid  out_data holds a sorted word (DRAIN only)
//   out_data   current sorted word, 0 when not draining
//   out_ready  consumer takes out_data this cycle
//   busy       high on every compare cycle
//   done       one-cycle pulse on the first DRAIN cycle
//
// Every output decodes from registered state only.

module compare_sort_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             descend,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [IdxW-1:0] idx_t;

  localparam idx_t LastIdx  = idx_t'(DEPTH - 1);
  // Highest compare index of pass 0, and also the last legal pass number.
  localparam idx_t LastPass = idx_t'(DEPTH - 2);
  localparam idx_t IdxOne   = idx_t'(1);

  typedef enum logic [1:0] {
    StLoad,
    StSort,
    StDrain
  } state_e;

  state_e           state_q, state_d;
  idx_t             wr_idx_q, wr_idx_d;
  idx_t             rd_idx_q, rd_idx_d;
  idx_t             j_q, j_d;
  idx_t             pass_q, pass_d;
  logic             swapped_q, swapped_d;
  logic             order_q, order_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // ---------------------------------------------------------------------------
  // Comparator: the one arithmetic resource, always looking at mem[j] vs mem[j+1].
  // ---------------------------------------------------------------------------
  idx_t             j_nxt;
  logic [WIDTH-1:0] cmp_a, cmp_b;
  logic             cmp_gt, cmp_lt;
  logic             swap_en;
  logic             pass_end;
  logic             pass_swapped;

  always_comb begin
    j_nxt  = j_q + IdxOne;
    cmp_a  = mem_q[j_q];
    cmp_b  = mem_q[j_nxt];
    cmp_gt = (cmp_a > cmp_b);
    cmp_lt = (cmp_a < cmp_b);
    // Equal words match neither flag, so they never swap and the sort is stable.
    swap_en = order_q ? cmp_lt : cmp_gt;
    // Each pass pushes one more extreme word to the tail, so it gets one shorter.
    pass_end = (j_q == (LastPass - pass_q));
    // Include this cycle's compare: the last compare of a pass may be its only swap.
    pass_swapped = swapped_q | swap_en;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    j_d       = j_q;
    pass_d    = pass_q;
    swapped_d = swapped_q;
    order_d   = order_q;
    done_d    = 1'b0;
    mem_d     = mem_q;

    unique case (state_q)
      StLoad: begin
        if (in_valid) begin
          mem_d[wr_idx_q] = in_data;
          wr_idx_d        = wr_idx_q + IdxOne;
          if (wr_idx_q == LastIdx) begin
            order_d   = descend;
            j_d       = '0;
            pass_d    = '0;
            swapped_d = 1'b0;
            state_d   = StSort;
          end
        end
      end

      StSort: begin
        if (swap_en) begin
          mem_d[j_q]   = cmp_b;
          mem_d[j_nxt] = cmp_a;
        end
        if (pass_end) begin
          // A clean pass means everything is ordered; the last pass is always final.
          if (!pass_swapped || (pass_q == LastPass)) begin
            state_d = StDrain;
            done_d  = 1'b1;
          end else begin
            pass_d    = pass_q + IdxOne;
            j_d       = '0;
            swapped_d = 1'b0;
          end
        end else begin
          j_d       = j_nxt;
          swapped_d = pass_swapped;
        end
      end

      StDrain: begin
        if (out_ready) begin
          if (rd_idx_q == LastIdx) begin
            rd_idx_d = '0;
            wr_idx_d = '0;
            state_d  = StLoad;
          end else begin
            rd_idx_d = rd_idx_q + IdxOne;
          end
        end
      end

      default: begin
        state_d = StLoad;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StLoad;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      j_q       <= '0;
      pass_q    <= '0;
      swapped_q <= 1'b0;
      order_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
      j_q       <= j_d;
      pass_q    <= pass_d;
      swapped_q <= swapped_d;
      order_q   <= order_d;
      done_q    <= done_d;
    end
  end

  // Word storage carries no reset; it is always fully rewritten before use.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = (state_q == StLoad);
    busy      = (state_q == StSort);
    out_valid = (state_q == StDrain);
    done      = done_q;
    // Gate so unreset storage never leaks onto out_data outside DRAIN.
    out_data  = out_valid ? mem_q[rd_idx_q] : '0;
  end

endmodule

// File: doc/compare_sort_ctrl.md
Name: compare_sort_ctrl

Overview:
- Sequencing controller around a single WIDTH-bit magnitude comparator (gt/eq/lt flags of A vs B).
- Accepts a burst of DEPTH unsigned words, sorts them in place with a bubble sort that issues one comparison per cycle, then streams the sorted words out.
- Sits between a producer and a consumer, both using valid/ready handshakes. The comparator instance is the only arithmetic resource.

Parameters:
- WIDTH, 4, data word width in bits (unsigned).
- DEPTH, 8, words per burst; legal range 2..64.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer has a word on in_data.
- in_data  input  WIDTH  word to load.
- in_ready  output  1  block accepts a word this cycle.
- descend  input  1  sort order; 0 = ascending, 1 = descending; sampled on the cycle the last word loads.
- out_valid  output  1  out_data holds a sorted word.
- out_data  output  WIDTH  current sorted word, index 0 first.
- out_ready  input  1  consumer takes out_data this cycle.
- busy  output  1  high in every SORT cycle (one comparison issued per cycle).
- done  output  1  one-cycle pulse on the first DRAIN cycle.

Behaviour:
- Storage:
  - mem[0..DEPTH-1] of WIDTH bits.
  - Index counters are clog2(DEPTH) bits wide, plus a pass counter and a swapped flag.
- Asynchronous reset, applied immediately regardless of state:
  - state=LOAD, all counters 0, swapped=0, latched order=0.
  - Outputs: in_ready=1, out_valid=0, busy=0, done=0, out_data=0.
  - mem contents are not reset.
- LOAD:
  - in_ready=1.
  - On in_valid&in_ready: mem[wr_idx]<=in_data, wr_idx++.
  - When the word written is at wr_idx=DEPTH-1: latch descend, j=0, pass=0, swapped=0, go to SORT on the same edge.
- SORT (busy=1, in_ready=0, out_valid=0):
  - Each cycle, drive comparator A=mem[j], B=mem[j+1].
  - Swap condition: ascending uses gt, descending uses lt.
  - If the condition holds: swap mem[j] and mem[j+1] on this edge and set swapped=1.
  - Equal words are never swapped, so the sort is stable.
  - Pass end is j == DEPTH-2-pass.
    - If no swap occurred in the pass (including the final compare), or pass == DEPTH-2: go to DRAIN.
    - Otherwise: pass++, j=0, swapped=0.
  - Any other cycle: j++.
  - Busy cycle counts:
    - Already-ordered input: exactly DEPTH-1 cycles.
    - Worst case: DEPTH*(DEPTH-1)/2 cycles.
- DRAIN:
  - out_valid=1, out_data=mem[rd_idx], in_ready=0.
  - done=1 only on the first DRAIN cycle.
  - On out_valid&out_ready: rd_idx++.
  - On the transfer of index DEPTH-1: rd_idx=0, wr_idx=0, go to LOAD. in_ready=1 from the next cycle.
  - out_data must stay stable while out_ready=0.
- in_valid during SORT/DRAIN and out_ready during LOAD/SORT are ignored. No data is lost or duplicated.
- No bypass: a word loaded in a burst never appears at the output before the whole burst is sorted.
- Transitions are registered. All outputs decode from registered state and have no combinational path from inputs.

Test Plan:
- Ascending, worst case: load F,E,D,C,B,A,9,8 with out_ready=1, descend=0 -> busy high exactly 28 cycles; done pulses once; out stream 8,9,A,B,C,D,E,F in 8 consecutive cycles.
- Pre-sorted: load 1,2,3,4,5,6,7,8 -> busy exactly 7 cycles; output 1..8 unchanged.
- Descending with duplicates: load 5,5,3,F,0,5,3,A with descend=1 -> output F,A,5,5,5,3,3,0. Order can only be checked by value; equal words are never swapped.
- Output backpressure: out_ready pattern 1,0,0,1,0,1... -> out_data held constant while out_ready=0; in_ready stays 0 until the 8th word transfers, then goes to 1 the next cycle; a second burst loads and sorts correctly.
- Reset mid-SORT: assert rst_n=0 on the 10th busy cycle of the reverse burst -> busy, out_valid and done drop immediately; in_ready=1 after release; a fresh load of 3,1,2,0,7,6,5,4 outputs 0..7.
- Protocol noise: hold in_valid=1 with changing in_data through SORT and DRAIN, and pulse out_ready during LOAD -> no extra words written, wr_idx unaffected, output sequence unchanged.
